// File: rtl/syscall_print_engine_if.sv
// Signal bundle between the print engine, the CPU data path, data memory and the console.
// The slave modport is the engine's view; master is the surrounding system.
interface syscall_print_engine_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cpu_mem_read;
    logic              cpu_mem_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [31:0]       cpu_write_data;
    logic [31:0]       cpu_read_data;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [31:0]       mem_read_data;

    logic              print_start;
    logic [ADDR_W-1:0] print_addr;
    logic              print_busy;
    logic              print_done;
    logic              print_overflow;

    logic              char_valid;
    logic [7:0]        char_data;
    logic              char_ready;

    modport slave (
        input  cpu_mem_read, cpu_mem_write, cpu_address, cpu_write_data,
        output cpu_read_data,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data,
        input  print_start, print_addr,
        output print_busy, print_done, print_overflow,
        output char_valid, char_data,
        input  char_ready
    );

    modport master (
        output cpu_mem_read, cpu_mem_write, cpu_address, cpu_write_data,
        input  cpu_read_data,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data,
        output print_start, print_addr,
        input  print_busy, print_done, print_overflow,
        input  char_valid, char_data,
        output char_ready
    );
endinterface

// File: rtl/syscall_print_engine.sv
// Print-string syscall engine: steals idle data-memory cycles from the CPU, fetches words and
// streams their bytes little-endian to the console until NUL or MAX_LEN characters.
module syscall_print_engine #(
    parameter int unsigned MAX_LEN = 256,
    parameter int unsigned ADDR_W  = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    syscall_print_engine_if.slave bus
);
    localparam int unsigned LenW = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       word_q, word_d;
    logic [LenW-1:0]   len_q, len_d;
    logic              ovf_q, ovf_d;

    logic       cpu_req;
    logic       grant;
    logic       at_limit;
    logic [7:0] cur_byte;

    assign cpu_req  = bus.cpu_mem_read | bus.cpu_mem_write;
    assign grant    = (state_q == StFetch) && !cpu_req;
    assign at_limit = (len_q == LenW'(MAX_LEN));

    always_comb begin
        cur_byte = 8'h00;
        unique case (ptr_q[1:0])
            2'd0: cur_byte = word_q[7:0];
            2'd1: cur_byte = word_q[15:8];
            2'd2: cur_byte = word_q[23:16];
            2'd3: cur_byte = word_q[31:24];
            default: cur_byte = 8'h00;
        endcase
    end

    // CPU always wins the memory port; the engine only reads, and only while fetching.
    always_comb begin
        bus.cpu_read_data = bus.mem_read_data;
        if (cpu_req) begin
            bus.mem_read       = bus.cpu_mem_read;
            bus.mem_write      = bus.cpu_mem_write;
            bus.mem_address    = bus.cpu_address;
            bus.mem_write_data = bus.cpu_write_data;
        end else if (state_q == StFetch) begin
            bus.mem_read       = 1'b1;
            bus.mem_write      = 1'b0;
            bus.mem_address    = {ptr_q[ADDR_W-1:2], 2'b00};
            bus.mem_write_data = 32'h0;
        end else begin
            bus.mem_read       = 1'b0;
            bus.mem_write      = 1'b0;
            bus.mem_address    = '0;
            bus.mem_write_data = 32'h0;
        end
    end

    always_comb begin
        bus.char_valid     = (state_q == StEmit) && (cur_byte != 8'h00) && !at_limit;
        bus.char_data      = bus.char_valid ? cur_byte : 8'h00;
        bus.print_busy     = (state_q != StIdle);
        bus.print_done     = (state_q == StDone);
        bus.print_overflow = (state_q == StDone) && ovf_q;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        word_d  = word_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.print_start) begin
                    ptr_d   = bus.print_addr;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                if (grant) begin
                    word_d  = bus.mem_read_data;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (cur_byte == 8'h00) begin
                    ovf_d   = 1'b0;
                    state_d = StDone;
                end else if (at_limit) begin
                    ovf_d   = 1'b1;
                    state_d = StDone;
                end else if (bus.char_ready) begin
                    ptr_d = ptr_q + 1'b1;
                    len_d = len_q + 1'b1;
                    // Last byte of the latched word consumed: the next one needs a fetch.
                    if (ptr_q[1:0] == 2'b11) begin
                        state_d = StFetch;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            word_q  <= 32'h0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_syscall_print_engine.sv
// Scoreboard bench for syscall_print_engine: a string-walking reference model queues expected
// characters and completions; a negedge monitor checks them along with port arbitration.
module tb_syscall_print_engine;
    localparam int unsigned MaxLen = 4;
    localparam int unsigned AddrW  = 32;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    syscall_print_engine_if #(.ADDR_W(AddrW)) bus ();

    syscall_print_engine #(.MAX_LEN(MaxLen), .ADDR_W(AddrW)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [31:0] mem [64];
    assign bus.mem_read_data = mem[bus.mem_address[7:2]];

    typedef struct {
        bit         is_done;
        bit         ovf;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   exp_fetch_q[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   fetch_cnt = 0;
    int   start_cyc = 0;
    bit   first_pending = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int   cfg_exp_lat = -1;
    int   cfg_hold = 0;
    int   cfg_stall_idx = -1;
    int   cfg_stall_len = 0;
    bit   cfg_rnd = 1'b0;
    bit   cfg_wr = 1'b0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return w[8*a[1:0] +: 8];
    endfunction

    // Walk the string in memory byte by byte as the syscall defines it.
    task automatic model_push(input logic [31:0] a0);
        logic [31:0] a;
        logic [7:0]  b;
        exp_t        e;
        a = a0;
        for (int n = 0; n <= int'(MaxLen); n++) begin
            b = mem_byte(a);
            if (b == 8'h00) begin
                e = '{is_done: 1'b1, ovf: 1'b0, data: 8'h00};
                exp_q.push_back(e);
                break;
            end
            if (n == int'(MaxLen)) begin
                e = '{is_done: 1'b1, ovf: 1'b1, data: 8'h00};
                exp_q.push_back(e);
                break;
            end
            e = '{is_done: 1'b0, ovf: 1'b0, data: b};
            exp_q.push_back(e);
            a = a + 1;
        end
        exp_fetch_q.push_back(int'((a >> 2) - (a0 >> 2)) + 1);
    endtask

    always @(negedge clk) begin
        logic creq;
        exp_t e;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            cyc++;
            creq = bus.cpu_mem_read | bus.cpu_mem_write;
            if (creq) begin
                check("arb_cpu_ctrl", {bus.mem_read, bus.mem_write, bus.mem_address},
                      {bus.cpu_mem_read, bus.cpu_mem_write, bus.cpu_address});
                check("arb_cpu_wdata", bus.mem_write_data, bus.cpu_write_data);
            end else begin
                check("arb_eng_nowrite", {bus.mem_write, bus.mem_write_data}, 64'h0);
                if (!bus.print_busy) check("arb_idle", {bus.mem_read, bus.mem_address}, 64'h0);
                if (bus.mem_read) begin
                    fetch_cnt++;
                    check("fetch_align", bus.mem_address[1:0], 64'h0);
                end
            end
            check("cpu_rdata", bus.cpu_read_data, mem[bus.mem_address[7:2]]);
            if (prev_stall) check("bp_hold", {bus.char_valid, bus.char_data}, {1'b1, prev_data});
            if (!bus.print_done) check("ovf_without_done", bus.print_overflow, 64'h0);
            if (bus.char_valid && first_pending) begin
                first_pending = 1'b0;
                if (cfg_exp_lat >= 0) check("first_char_latency", cyc - start_cyc, cfg_exp_lat);
            end
            if (bus.char_valid && bus.char_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_char", {1'b1, bus.char_data}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("char", {1'b0, bus.char_data}, {e.is_done, e.data});
                end
            end
            if (bus.print_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_ovf", {1'b1, bus.print_overflow}, {e.is_done, e.ovf});
                end
                if (exp_fetch_q.size() != 0) check("fetch_count", fetch_cnt, exp_fetch_q.pop_front());
            end
            prev_stall = bus.char_valid && !bus.char_ready;
            prev_data  = bus.char_data;
        end
    end

    task automatic drive_idle();
        bus.print_start    = 1'b0;
        bus.cpu_mem_read   = 1'b0;
        bus.cpu_mem_write  = 1'b0;
        bus.cpu_write_data = 32'h0;
        bus.char_ready     = 1'b1;
    endtask

    task automatic run_req(input logic [31:0] addr);
        int   d0;
        int   stall_rem;
        bit   wr_pending;
        bit   wr_issued;
        bit   finished;
        logic [31:0] wr_addr;
        model_push(addr);
        @(posedge clk);
        #1;
        drive_idle();
        bus.print_start = 1'b1;
        bus.print_addr  = addr;
        start_cyc       = cyc + 1;
        first_pending   = 1'b1;
        hs_cnt          = 0;
        fetch_cnt       = 0;
        d0              = done_cnt;
        stall_rem       = cfg_stall_len;
        wr_pending      = 1'b0;
        wr_issued       = 1'b0;
        wr_addr         = 32'h0;
        finished        = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #1;
            drive_idle();
            if (wr_pending) begin
                mem[wr_addr[7:2]] = 32'h0;
                wr_pending = 1'b0;
            end
            if (done_cnt != d0) begin
                finished = 1'b1;
                break;
            end
            bus.cpu_address = $urandom;
            if (t < cfg_hold) bus.cpu_mem_read = 1'b1;
            if (cfg_rnd) begin
                if ($urandom_range(0, 3) == 0) bus.cpu_mem_read = 1'b1;
                bus.char_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) begin
                    bus.print_start = 1'b1;
                    bus.print_addr  = $urandom;
                end
            end
            if (bus.char_valid && hs_cnt == cfg_stall_idx && stall_rem > 0) begin
                bus.char_ready = 1'b0;
                stall_rem--;
            end
            // Overwrite the word the engine has latched; its output must not change.
            if (cfg_wr && !wr_issued && bus.char_valid && hs_cnt == 0) begin
                bus.cpu_mem_write  = 1'b1;
                bus.cpu_address    = addr;
                bus.cpu_write_data = 32'h0;
                wr_addr            = addr;
                wr_pending         = 1'b1;
                wr_issued          = 1'b1;
            end
        end
        if (!finished) check("request_timeout", 0, 1);
        first_pending = 1'b0;
    endtask

    task automatic set_cfg(input int lat, input int hold, input int sidx, input int slen,
                           input bit rnd, input bit wr);
        cfg_exp_lat   = lat;
        cfg_hold      = hold;
        cfg_stall_idx = sidx;
        cfg_stall_len = slen;
        cfg_rnd       = rnd;
        cfg_wr        = wr;
    endtask

    initial begin
        reset_n         = 1'b0;
        bus.print_addr  = 32'h0;
        bus.cpu_address = 32'h0;
        drive_idle();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        #1;
        check("reset_outputs", {bus.print_busy, bus.print_done, bus.print_overflow,
                                bus.char_valid, bus.char_data}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // "Hi!" aligned, then the same string under contention, backpressure and a CPU write.
        mem[60] = 32'h0021_6948;
        set_cfg(2, 0, -1, 0, 1'b0, 1'b0);
        run_req(32'h7FFF_FBF0);
        set_cfg(7, 5, -1, 0, 1'b0, 1'b0);
        run_req(32'h7FFF_FBF0);
        set_cfg(2, 0, 1, 3, 1'b0, 1'b0);
        run_req(32'h7FFF_FBF0);
        set_cfg(2, 0, -1, 0, 1'b0, 1'b1);
        run_req(32'h7FFF_FBF0);
        mem[60] = 32'h0021_6948;

        // Unaligned start spanning two words; hits exactly MaxLen chars then NUL.
        mem[60] = 32'h6C6C_0000;
        mem[61] = 32'h0000_6F65;
        set_cfg(2, 0, -1, 0, 1'b0, 1'b0);
        run_req(32'h7FFF_FBF2);

        // Overflow: no NUL within MaxLen characters.
        for (int i = 60; i < 64; i++) mem[i] = 32'h4141_4141;
        run_req(32'h7FFF_FBF0);

        // Reset during the second character, then a clean restart elsewhere.
        mem[60] = 32'h0021_6948;
        mem[61] = 32'h0000_6F65;
        mem[62] = 32'h0;
        model_push(32'h7FFF_FBF0);
        @(posedge clk);
        #1;
        drive_idle();
        bus.print_start = 1'b1;
        bus.print_addr  = 32'h7FFF_FBF0;
        hs_cnt          = 0;
        @(posedge clk);
        #1;
        bus.print_start = 1'b0;
        for (int t = 0; t < 20 && !(bus.char_valid && hs_cnt == 1); t++) begin
            @(posedge clk);
            #1;
        end
        check("reached_second_char", {bus.char_valid, bus.char_data}, {1'b1, 8'h69});
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {bus.print_busy, bus.print_done, bus.print_overflow,
                                      bus.char_valid, bus.char_data}, 64'h0);
        exp_q.delete();
        exp_fetch_q.delete();
        repeat (2) @(posedge clk);
        check("reset_hold_outputs", {bus.print_busy, bus.print_done, bus.char_valid}, 64'h0);
        #3;
        reset_n = 1'b1;
        set_cfg(2, 0, -1, 0, 1'b0, 1'b0);
        run_req(32'h7FFF_FBF4);

        // Random strings, random CPU traffic, random backpressure and spurious starts.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 64; i++) begin
                logic [31:0] w;
                for (int k = 0; k < 4; k++) begin
                    w[8*k +: 8] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                end
                mem[i] = w;
            end
            set_cfg(-1, 0, -1, 0, 1'b1, 1'b0);
            run_req(32'h7FFF_FB00 | 32'($urandom_range(0, 255)));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
